mem_stage_sram_ctrl: RTL
========================

Name: mem_stage_sram_ctrl

Overview:
- Memory-side consumer of the execution stage's data-access request (ALU result as address, Rm value as store data, read/write enables).
- Converts each 32-bit load/store into two timed 16-bit accesses on the external asynchronous SRAM.
- Returns load data and deasserts ready to freeze the pipeline while an access is in flight.
- Sits between the EX/MEM pipeline register and the MEM/WB register.

Parameters:
- BASE_ADDR, 1024: byte address subtracted from the request address before mapping to SRAM.
- WAIT_CYCLES, 5: cycles each 16-bit half-access is held on the SRAM pins; legal range is 2 or more.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  store request from EX/MEM.
- rd_en  input  1  load request from EX/MEM.
- address  input  32  byte address (ALU result).
- write_data  input  32  store data (Rm value).
- read_data  output  32  last completed load word.
- ready  output  1  high when the pipeline may advance.
- sram_addr  output  18  SRAM halfword address.
- sram_dq_out  output  16  data driven to SRAM.
- sram_dq_oe  output  1  tri-state enable for sram_dq_out.
- sram_dq_in  input  16  data read from SRAM.
- sram_we_n  output  1  SRAM write strobe, active-low.
- sram_oe_n  output  1  SRAM output enable, active-low.

Behaviour:
- States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE. A cycle counter runs 0..WAIT_CYCLES-1 within each half state.
- Reset (rst=0, asynchronous): state=IDLE, counter=0, read_data=0, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
- Reset mid-access aborts immediately and the partial write is abandoned; sram_we_n goes high without waiting for clk.
- IDLE:
  - ready = ~(wr_en | rd_en), combinational.
  - On a clock edge with a request, latch address, write_data and the request type, then go to WR_LO (write) or RD_LO (read).
  - If wr_en and rd_en are both high, the write wins and the read is dropped.
- Address mapping:
  - word = (address - BASE_ADDR) >> 2, 32-bit subtract.
  - sram_addr = {word[16:0], half}, with half=0 for the LO state and half=1 for the HI state.
  - Upper bits are truncated with no range check, so addresses below BASE_ADDR wrap.
  - address[1:0] is ignored.
- WR_LO / WR_HI:
  - sram_dq_oe=1 and sram_oe_n=1.
  - sram_dq_out = latched data [15:0] in WR_LO, [31:16] in WR_HI.
  - sram_we_n=0 for counter 0..WAIT_CYCLES-2 and 1 on the last count, so address and data are stable at the rising edge of we_n.
  - On the last count, WR_LO goes to WR_HI and WR_HI goes to DONE.
- RD_LO / RD_HI:
  - sram_oe_n=0, sram_dq_oe=0, sram_we_n=1.
  - On the last count, sram_dq_in is captured into an internal low half (RD_LO) or high half (RD_HI).
  - On leaving RD_HI, read_data is updated with the full 32-bit word.
- DONE: ready=1 for exactly one cycle, then unconditionally return to IDLE. The pipeline advances on this edge.
- Outside DONE, and outside IDLE with no request, ready=0. All SRAM controls are decoded from registered state and counter.
- Latency (W = WAIT_CYCLES):
  - Request visible in IDLE at cycle 0.
  - ready is low for cycles 0..2W and high at cycle 2W+1.
  - With W=5: 11 stall cycles.
- read_data holds its value across writes and idle periods; it changes only on completion of a read.
- A request present in IDLE in the cycle immediately after DONE is a new access (back-to-back requests are allowed).
- Inputs are not re-sampled during an access; a frozen pipeline holds them stable, but the latched copies are authoritative.

Test Plan:
- Reset: hold rst=0 with wr_en=1 -> ready=1 (IDLE, rst overrides), sram_we_n=1, sram_oe_n=1, read_data=0. Release rst -> ready drops combinationally.
- Store: address=1032, write_data=32'hDEADBEEF, wr_en=1, W=5.
  - sram_addr=4 with dq=16'hBEEF for 5 cycles (we_n low 4 cycles), then sram_addr=5 with dq=16'hDEAD.
  - ready high only at cycle 11.
- Load after store: rd_en=1, address=1032, SRAM model returns stored halves -> read_data=32'hDEADBEEF when ready pulses; sram_dq_oe=0 throughout.
- Collision and back-to-back: wr_en=rd_en=1 -> write sequence only and read_data unchanged. Then a load presented the cycle after DONE -> RD_LO starts with no idle gap.
- Reset mid-write: assert rst during WR_HI counter=2 -> sram_we_n=1 and state IDLE immediately. Next load of the same address returns the new low half and the old high half.
- Wrap: address=1020 (below BASE_ADDR) -> word=0x3FFFFFFF, sram_addr=18'h3FFFE then 18'h3FFFF.

Source files
------------

// File: rtl/mem_stage_sram_ctrl_if.sv
// MEM stage data-access bundle between EX/MEM and the SRAM controller.
// Master is the pipeline side; slave is the controller.
interface mem_stage_sram_ctrl_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en,
    output rd_en,
    output address,
    output write_data,
    input  read_data,
    input  ready
  );

  modport slave (
    input  wr_en,
    input  rd_en,
    input  address,
    input  write_data,
    output read_data,
    output ready
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage controller: splits each 32-bit load/store into two timed
// 16-bit accesses on an asynchronous SRAM and stalls the pipeline meanwhile.
module mem_stage_sram_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_stage_sram_ctrl_if.slave bus,
  output logic [17:0]          sram_addr,
  output logic [15:0]          sram_dq_out,
  output logic                 sram_dq_oe,
  input  logic [15:0]          sram_dq_in,
  output logic                 sram_we_n,
  output logic                 sram_oe_n
);

  localparam int CW = $clog2(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] PRE  = CW'(WAIT_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE,
    WR_LO,
    WR_HI,
    RD_LO,
    RD_HI,
    DONE
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [16:0]    word_q;
  logic [31:0]    data_q;
  logic [15:0]    lo_q;
  logic [31:0]    offset;
  logic           req;
  logic           unused_bits;

  assign offset      = bus.address - 32'(BASE_ADDR);
  assign unused_bits = ^{offset[31:19], offset[1:0]};
  assign req         = bus.wr_en | bus.rd_en;

  // Reset forces ready high so a held request cannot stall out of reset.
  always_comb begin
    bus.ready = 1'b0;
    if (!rst)
      bus.ready = 1'b1;
    else if (state == DONE)
      bus.ready = 1'b1;
    else if (state == IDLE)
      bus.ready = ~req;
  end

  // SRAM pins are registered one step ahead, so they always match
  // the current state/counter pair without any combinational glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      word_q        <= '0;
      data_q        <= '0;
      lo_q          <= '0;
      bus.read_data <= '0;
      sram_addr     <= '0;
      sram_dq_out   <= '0;
      sram_dq_oe    <= 1'b0;
      sram_we_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            word_q    <= offset[18:2];
            data_q    <= bus.write_data;
            cnt       <= '0;
            sram_addr <= {offset[18:2], 1'b0};
            if (bus.wr_en) begin
              state       <= WR_LO;
              sram_dq_oe  <= 1'b1;
              sram_dq_out <= bus.write_data[15:0];
              sram_we_n   <= 1'b0;
            end else begin
              state     <= RD_LO;
              sram_oe_n <= 1'b0;
            end
          end
        end
        WR_LO, WR_HI: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (state == WR_LO) begin
              state       <= WR_HI;
              sram_addr   <= {word_q, 1'b1};
              sram_dq_out <= data_q[31:16];
              sram_we_n   <= 1'b0;
            end else begin
              state      <= DONE;
              sram_dq_oe <= 1'b0;
              sram_we_n  <= 1'b1;
            end
          end else begin
            cnt       <= cnt + 1'b1;
            sram_we_n <= (cnt == PRE);
          end
        end
        RD_LO: begin
          if (cnt == LAST) begin
            cnt       <= '0;
            lo_q      <= sram_dq_in;
            state     <= RD_HI;
            sram_addr <= {word_q, 1'b1};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD_HI: begin
          if (cnt == LAST) begin
            cnt           <= '0;
            bus.read_data <= {sram_dq_in, lo_q};
            state         <= DONE;
            sram_oe_n     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
